// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter slice: the next-value
// selector used to make the load / increment / hold priority explicit.
package pc_pkg;

    // Source of the slice register's next value.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_INC  = 2'd2
    } pc_sel_e;

endpackage : pc_pkg

// File: rtl/pc.sv
// One WIDTH-bit slice of the 6502 program counter. Slices cascade through
// carry_in/carry_out; the low slice has carry_in tied high so a fetch cycle
// increments the whole PC, with the carry rippling combinationally upward.
module pc
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             latch,
    input  logic             sync,
    input  logic             carry_in,
    output logic [WIDTH-1:0] addr,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_incr;
    pc_sel_e          w_sel;

    // Choose the next-value source: a load beats an increment, and only an
    // explicit 1 on latch/sync counts as asserted.
    always_comb begin
        w_sel = SEL_HOLD;
        if (latch == 1'b1) begin
            w_sel = SEL_LOAD;
        end else if ((sync == 1'b1) && (carry_in == 1'b1)) begin
            w_sel = SEL_INC;
        end else begin
            w_sel = SEL_HOLD;
        end
    end

    // Form the next register value from the selected source; the
    // increment wraps naturally modulo 2^WIDTH.
    always_comb begin
        w_incr = r_addr + ONE;
        w_next = r_addr;
        case (w_sel)
            SEL_LOAD: w_next = data;
            SEL_INC:  w_next = w_incr;
            SEL_HOLD: w_next = r_addr;
            default:  w_next = r_addr;
        endcase
    end

    // Slice register with asynchronous reset to RESET_VALUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= RESET_VALUE;
        end else begin
            r_addr <= w_next;
        end
    end

    assign addr = r_addr;

    // Carry ignores sync and latch so the cascade resolves within one cycle;
    // an upper slice that is latching simply disregards it.
    assign carry_out = carry_in & (r_addr == ALL_ONES);

endmodule : pc

// File: tb/tb_pc.sv
// Bench for the pc slice: two slices cascaded into a 16-bit PC, driven by
// a table of directed vectors plus hand-written reset sequences.
module tb_pc;

    logic       clk;
    logic       rst;
    logic [7:0] data_l, data_h;
    logic       latch_l, latch_h;
    logic       sync;
    logic       ci_l;
    logic [7:0] addr_l, addr_h;
    logic       co_l, co_h;

    int errors;
    int checks;

    pc #(.WIDTH(8), .RESET_VALUE(8'h00)) u_lo (
        .clk(clk), .rst(rst), .data(data_l), .latch(latch_l), .sync(sync),
        .carry_in(ci_l), .addr(addr_l), .carry_out(co_l)
    );

    pc #(.WIDTH(8), .RESET_VALUE(8'h00)) u_hi (
        .clk(clk), .rst(rst), .data(data_h), .latch(latch_h), .sync(sync),
        .carry_in(co_l), .addr(addr_h), .carry_out(co_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ll;
        logic        lh;
        logic [7:0]  dl;
        logic [7:0]  dh;
        logic        sy;
        logic        ci;
        logic [15:0] ea;
        logic        ecl;
        logic        ech;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [0:NVEC-1];

    function automatic vec_t mk(input logic ll, input logic lh,
                                input logic [7:0] dl, input logic [7:0] dh,
                                input logic sy, input logic ci,
                                input logic [15:0] ea, input logic ecl,
                                input logic ech);
        vec_t v;
        v.ll = ll; v.lh = lh; v.dl = dl; v.dh = dh; v.sy = sy; v.ci = ci;
        v.ea = ea; v.ecl = ecl; v.ech = ech;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] ea,
                         input logic ecl, input logic ech);
        checks++;
        if ({addr_h, addr_l} !== ea || co_l !== ecl || co_h !== ech) begin
            errors++;
            $display("FAIL %s: got addr=%h co_l=%b co_h=%b, expected addr=%h co_l=%b co_h=%b",
                     name, {addr_h, addr_l}, co_l, co_h, ea, ecl, ech);
        end
    endtask

    task automatic drive(input logic ll, input logic lh, input logic [7:0] dl,
                         input logic [7:0] dh, input logic sy, input logic ci);
        latch_l = ll; latch_h = lh; data_l = dl; data_h = dh; sync = sy; ci_l = ci;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //       ll    lh    dl     dh     sy    ci    addr      co_l  co_h
        vecs[0]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0); // hold after reset
        vecs[1]  = mk(1'b1, 1'b0, 8'hFC, 8'h00, 1'b0, 1'b1, 16'h00FC, 1'b0, 1'b0); // load low
        vecs[2]  = mk(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0); // load high
        vecs[3]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0); // fetch
        vecs[4]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0); // fetch
        vecs[5]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1); // both carries
        vecs[6]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0); // 16-bit wrap
        vecs[7]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0); // load 0x10
        vecs[8]  = mk(1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 1'b1, 16'h0080, 1'b0, 1'b0); // latch beats inc
        vecs[9]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b0); // no carry_in: hold
        vecs[10] = mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0); // carry w/o sync
        vecs[11] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0); // ripple into high
        vecs[12] = mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 16'h01FF, 1'b1, 1'b0); // low to FF
        vecs[13] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h01FF, 1'b0, 1'b0); // carry_in gates carry
        vecs[14] = mk(1'b0, 1'b1, 8'h00, 8'h42, 1'b1, 1'b1, 16'h4200, 1'b0, 1'b0); // wrap + high latch

        // Reset: inputs active but ignored; addr clears without a clock edge.
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b1);
        #1 rst = 1'b1;
        #1 check("reset_async", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_held_edge1", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_held_edge2", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release", 16'h0000, 1'b0, 1'b0);

        // Table of single-edge vectors.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ll, vecs[i].lh, vecs[i].dl, vecs[i].dh, vecs[i].sy, vecs[i].ci);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ecl, vecs[i].ech);
        end

        // Async reset mid-count, then counting resumes from 0x0001.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("count_before_rst", 16'h4201, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check("rst_mid_count", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("resume_first", 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("resume_second", 16'h0002, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc
